// File: rtl/sia_disp_pkg.sv
// Shared types and widths for the siacore work dispatcher; SIA_DISP_STATS_EN adds a busy-cycle field.
package sia_disp_pkg;

    localparam int WORK_W    = 640;
    localparam int TGT_W     = 64;
    localparam int NONCE_W   = 32;
    localparam int ID_W      = 8;
    localparam int NONCE_LSB = 256;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RUN,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [WORK_W-1:0] work;
        logic [TGT_W-1:0]  target;
        logic [ID_W-1:0]   id;
    } job_t;

    typedef struct packed {
        logic [ID_W-1:0]    id;
        logic [NONCE_W-1:0] nonce;
        logic               timeout;
`ifdef SIA_DISP_STATS_EN
        logic [31:0]        busy_cycles;
`endif
    } res_t;

endpackage

// File: rtl/sia_sync_fifo.sv
// Generic synchronous FIFO, head visible combinationally; one-cycle push-to-visible latency.
// No internal guarding: caller must not push when full (unless popping) nor pop when empty.
module sia_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/sia_work_dispatch.sv
// Queues host jobs, issues one at a time to siacore and returns tagged results; push-to-issue 2 cycles.
// Full result FIFO holds the FSM in DONE (no new issue); optional stats via SIA_DISP_STATS_EN.
module sia_work_dispatch
    import sia_disp_pkg::*;
#(
    parameter int          JOB_DEPTH = 4,
    parameter int          RES_DEPTH = 4,
    parameter logic [31:0] TIMEOUT   = 32'd100000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               job_valid,
    output logic               job_ready,
    input  logic [WORK_W-1:0]  job_work,
    input  logic [TGT_W-1:0]   job_target,
    input  logic [ID_W-1:0]    job_id,
    output logic [WORK_W-1:0]  core_work,
    output logic [TGT_W-1:0]   core_target,
    output logic               core_valid,
    input  logic               core_found,
    input  logic [NONCE_W-1:0] core_nonce,
    input  logic               core_busy,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [ID_W-1:0]    res_id,
    output logic [NONCE_W-1:0] res_nonce,
    output logic               res_timeout,
    output logic               idle
`ifdef SIA_DISP_STATS_EN
    ,
    output logic [31:0]        res_busy_cycles,
    output logic [15:0]        tot_found
`endif
);

    state_t      state, state_nxt;
    job_t        job_in, job_head;
    res_t        rec, res_head;
    logic        job_push, job_pop, job_full, job_empty;
    logic        res_push, res_pop, res_full, res_empty;
    logic [ID_W-1:0] cur_id;
    logic [31:0] timer;
    logic        run_timeout;

    assign job_in    = '{work: job_work, target: job_target, id: job_id};
    assign job_ready = !job_full;
    assign job_push  = job_valid && job_ready;

    sia_sync_fifo #(.WIDTH($bits(job_t)), .DEPTH(JOB_DEPTH)) u_job_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (job_push),
        .wdata (job_in),
        .pop   (job_pop),
        .rdata (job_head),
        .full  (job_full),
        .empty (job_empty)
    );

    assign res_valid = !res_empty;
    assign res_pop   = res_valid && res_ready;

    sia_sync_fifo #(.WIDTH($bits(res_t)), .DEPTH(RES_DEPTH)) u_res_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (res_push),
        .wdata (rec),
        .pop   (res_pop),
        .rdata (res_head),
        .full  (res_full),
        .empty (res_empty)
    );

    // Head is gated so an empty FIFO presents zeros rather than stale storage.
    assign res_id      = res_valid ? res_head.id      : '0;
    assign res_nonce   = res_valid ? res_head.nonce   : '0;
    assign res_timeout = res_valid ? res_head.timeout : 1'b0;
    assign idle        = (state == ST_IDLE) && job_empty;
    assign run_timeout = (timer == TIMEOUT - 32'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        job_pop    = 1'b0;
        res_push   = 1'b0;
        core_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!job_empty) begin
                    job_pop   = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                core_valid = 1'b1;
                state_nxt  = ST_RUN;
            end
            ST_RUN: begin
                if (core_found || run_timeout) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                // A simultaneous pop frees a slot even when full.
                if (!res_full || res_pop) begin
                    res_push  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_work   <= '0;
            core_target <= '0;
            cur_id      <= '0;
            timer       <= '0;
            rec.id      <= '0;
            rec.nonce   <= '0;
            rec.timeout <= 1'b0;
        end else begin
            if (job_pop) begin
                core_work   <= job_head.work;
                core_target <= job_head.target;
                cur_id      <= job_head.id;
            end
            if (state == ST_ISSUE)    timer <= '0;
            else if (state == ST_RUN) timer <= timer + 32'd1;
            if (state == ST_RUN) begin
                if (core_found) begin
                    rec.id      <= cur_id;
                    rec.nonce   <= core_nonce;
                    rec.timeout <= 1'b0;
                end else if (run_timeout) begin
                    rec.id      <= cur_id;
                    rec.nonce   <= '0;
                    rec.timeout <= 1'b1;
                end
            end
        end
    end

`ifdef SIA_DISP_STATS_EN
    logic [31:0] busy_cnt, busy_nxt;

    assign busy_nxt        = (core_busy && busy_cnt != 32'hFFFF_FFFF) ? busy_cnt + 32'd1 : busy_cnt;
    assign res_busy_cycles = res_valid ? res_head.busy_cycles : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt        <= '0;
            rec.busy_cycles <= '0;
            tot_found       <= '0;
        end else begin
            if (state == ST_ISSUE)    busy_cnt <= {31'b0, core_busy};
            else if (state == ST_RUN) busy_cnt <= busy_nxt;
            if (state == ST_RUN && (core_found || run_timeout)) rec.busy_cycles <= busy_nxt;
            if (res_push && !rec.timeout) tot_found <= tot_found + 16'd1;
        end
    end
`else
    logic unused_busy;
    assign unused_busy = core_busy;
`endif

endmodule

// File: doc/sia_work_dispatch.md
Name: sia_work_dispatch

Overview:
- Host-side counterpart to siacore. Buffers mining jobs from the host (640-bit header, 64-bit target, 8-bit job ID).
- Issues one job at a time to siacore with a single-cycle valid pulse, then waits for found or a cycle timeout.
- Returns a tagged result record (job ID, nonce, timeout flag) through a ready/valid result FIFO.
- Sits between the host register/DMA interface and siacore.

Parameters:
- JOB_DEPTH, 4, job FIFO entries (power of 2, >=2)
- RES_DEPTH, 4, result FIFO entries (power of 2, >=2)
- TIMEOUT, 32'd100000, cycles after issue before the job is abandoned (>=2)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- job_valid  in  1  host offers a job
- job_ready  out  1  job FIFO not full
- job_work  in  640  block header; nonce field at [287:256], little-endian byte order
- job_target  in  64  difficulty target
- job_id  in  8  host tag, returned with the result
- core_work  out  640  header to siacore; stable from issue until the job ends
- core_target  out  64  target to siacore; stable like core_work
- core_valid  out  1  single-cycle start pulse to siacore
- core_found  in  1  siacore found a nonce (sampled every cycle)
- core_nonce  in  32  nonce; valid when core_found=1
- core_busy  in  1  siacore hashing
- res_valid  out  1  result FIFO not empty
- res_ready  in  1  host pops a result
- res_id  out  8  job ID of the head result
- res_nonce  out  32  found nonce; 0 on timeout
- res_timeout  out  1  1 = job abandoned by timeout
- idle  out  1  FSM in IDLE and job FIFO empty

Behaviour:
- Reset (rst_n=0, async): FSM=IDLE, both FIFOs empty, timer=0.
  - Outputs: core_valid=0, core_work=0, core_target=0, res_valid=0, res_id=0, res_nonce=0, res_timeout=0, job_ready=1, idle=1.
- Job FIFO:
  - Push on job_valid&job_ready. A push while full is impossible (job_ready=0); job_valid is ignored then.
  - Pointers are log2(JOB_DEPTH)+1 bits and wrap naturally. Full = MSBs differ and LSBs equal.
- FSM states: IDLE, ISSUE, RUN, DONE.
  - IDLE: if the job FIFO is non-empty, pop the head into the core_work/core_target/cur_id registers, then go to ISSUE. A push into an empty FIFO reaches the core no earlier than 2 cycles later (push cycle + IDLE pop).
  - ISSUE: core_valid=1 for exactly this cycle; timer cleared; go to RUN.
  - RUN:
    - timer increments each cycle.
    - core_found=1: capture {cur_id, core_nonce, timeout=0}, go to DONE.
    - Otherwise, timer==TIMEOUT-1: capture {cur_id, 32'h0, 1}, go to DONE.
    - found and timeout in the same cycle: found wins.
    - core_found while in IDLE, ISSUE or DONE: ignored, no result generated.
  - DONE: push the captured record into the result FIFO when it is not full, then go to IDLE. If the FIFO is full, stay in DONE holding the record; no new job is issued (backpressure).
- Result FIFO:
  - Head drives res_*; pop on res_valid&res_ready.
  - Push and pop in the same cycle while full is legal: occupancy unchanged, so DONE proceeds that cycle.
- core_work/core_target hold the last issued job while IDLE.
- Reset mid-job: state is lost, no result emitted; the host must resubmit.

Optional Feature:
- SIA_DISP_STATS_EN defined:
  - Extra output res_busy_cycles [31:0], stored per result record. It counts cycles with core_busy=1 between ISSUE and leaving RUN, saturating at 32'hFFFF_FFFF.
  - Extra output tot_found [15:0], counting non-timeout results pushed; wraps.
- Undefined: neither port exists, and the counters and extra FIFO width are absent.

Decomposition:
- Package sia_disp_pkg:
  - FSM state enum
  - WORK_W=640, TGT_W=64, NONCE_W=32, ID_W=8
  - NONCE_LSB=256
  - result record struct {id, nonce, timeout[, busy_cycles]}
- Sub-module sia_sync_fifo (WIDTH, DEPTH; push/pop/full/empty, data out = head, async active-low reset) is instantiated twice: job and result.

Test Plan:
- Single job: push id=8'h01, target=64'h0000_00FF_FFFF_FFFF; core model asserts found with nonce=32'h1234_5678 ten cycles after core_valid -> exactly one core_valid pulse 2 cycles after push; result {id=01, nonce=12345678, timeout=0}, res_valid 2 cycles after found.
- Timeout: TIMEOUT=16, core never finds -> core_valid then res_timeout=1, res_nonce=0, res_id matches, 16 cycles after the ISSUE cycle.
- Queue fill: push 5 jobs with JOB_DEPTH=4 and the core stalled -> job_ready=0 once 4 are buffered (the first is already popped into IDLE/ISSUE). All 5 issue in order and results return ids 0..4 in order.
- Result backpressure: res_ready=0, 5 finds with RES_DEPTH=4 -> 4 results buffered, FSM holds in DONE and no 6th issue. Raising res_ready drains all 5 in order.
- Race: found on the cycle timer==TIMEOUT-1 -> timeout=0 result with the core nonce. core_found pulse while IDLE -> no result.
- Reset mid-RUN: assert rst_n low for 1 cycle -> all outputs return to reset values immediately; res_valid=0, idle=1.
